// File: rtl/snake_step_ctrl_if.sv
// Signal bundle between the step controller and the joystick/datapath side.
// master = step controller, slave = datapath and input side.
`timescale 1ns/1ps
interface snake_step_ctrl_if;
   logic [3:0] i_Push;
   logic       i_Pause;
   logic       i_Ack;
   logic       i_Eat;
   logic       i_Dead;
   logic       o_Step;
   logic [1:0] o_Way;
   logic [4:0] o_Speed;
   logic       o_Boost;
   logic [2:0] o_State;
   logic       o_Timeout;

   modport master (
      input  i_Push, i_Pause, i_Ack, i_Eat, i_Dead,
      output o_Step, o_Way, o_Speed, o_Boost, o_State, o_Timeout
   );

   modport slave (
      output i_Push, i_Pause, i_Ack, i_Eat, i_Dead,
      input  o_Step, o_Way, o_Speed, o_Boost, o_State, o_Timeout
   );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake step scheduler: speed-paced step requests, direction latch, boost window, pause/stop; optional SNAKE_STEP_WDOG_EN ack watchdog.
// All outputs registered; o_Step is a 1-cycle pulse and the FSM holds in WAIT until i_Ack (or the watchdog fires).
`timescale 1ns/1ps
module snake_step_ctrl #(
   parameter int LST_CLK     = 1000,
   parameter int DEF_SPD     = 2,
   parameter int MAX_SPD     = 15,
   parameter int BOOST_STEPS = 16,
   parameter int WDOG_CYC    = 255
) (
   input logic               i_Clk,
   input logic               i_Rst,
   snake_step_ctrl_if.master bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   localparam int BW = (BOOST_STEPS < 2) ? 1 : $clog2(BOOST_STEPS + 1);

   localparam logic [25:0]   LST_W = 26'(LST_CLK);
   localparam logic [4:0]    DEF_W = 5'(DEF_SPD);
   localparam logic [4:0]    MAX_W = 5'(MAX_SPD);
   localparam logic [BW-1:0] BST_W = BW'(BOOST_STEPS);

   logic [2:0]    state;
   logic [24:0]   acc;
   logic          step;
   logic [1:0]    way;
   logic [1:0]    pend;
   logic [4:0]    speed;
   logic          boost;
   logic [BW-1:0] bcnt;

   logic [1:0]    push_dir;
   logic          push_any;
   logic [25:0]   sum;
   logic          hit;
   logic          reversal;
   logic [4:0]    speed_inc;
   logic [BW-1:0] bcnt_inc;
   logic          wd_fire;

   always_comb begin
      push_any = ~&bus.i_Push;
      push_dir = pend;
      if (!bus.i_Push[0])      push_dir = 2'd0;
      else if (!bus.i_Push[1]) push_dir = 2'd1;
      else if (!bus.i_Push[2]) push_dir = 2'd2;
      else if (!bus.i_Push[3]) push_dir = 2'd3;

      sum       = {1'b0, acc} + {21'd0, speed};
      hit       = (sum >= LST_W);
      reversal  = (pend == (way ^ 2'd1));
      speed_inc = (speed >= MAX_W) ? MAX_W : speed + 5'd1;
      bcnt_inc  = bcnt + 1'b1;
   end

`ifdef SNAKE_STEP_WDOG_EN
   localparam int WW = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYC - 1);

   logic [WW-1:0] wcnt;
   logic          tout;

   assign wd_fire = (state == ST_WAIT) && !bus.i_Ack && (wcnt == WD_LAST);

   // Counter restarts on every RUN->WAIT transition.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         wcnt <= '0;
         tout <= 1'b0;
      end else begin
         if (state == ST_RUN && !bus.i_Pause && hit) begin
            wcnt <= '0;
         end else if (state == ST_WAIT && !bus.i_Ack && !wd_fire) begin
            wcnt <= wcnt + 1'b1;
         end
         if (wd_fire) begin
            tout <= 1'b1;
         end
      end
   end

   assign bus.o_Timeout = tout;
`else
   assign wd_fire       = 1'b0;
   assign bus.o_Timeout = 1'b0;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         step  <= 1'b0;
         way   <= 2'd0;
         pend  <= 2'd0;
         speed <= DEF_W;
         boost <= 1'b0;
         bcnt  <= '0;
      end else begin
         step <= 1'b0;
         if (state != ST_STOP) begin
            pend <= push_dir;
         end

         case (state)
            ST_IDLE: begin
               if (push_any) begin
                  state <= ST_RUN;
                  way   <= push_dir;
                  acc   <= '0;
               end
            end

            ST_RUN: begin
               // Pause wins over a step landing in the same cycle.
               if (bus.i_Pause) begin
                  state <= ST_PAUSE;
               end else if (hit) begin
                  acc   <= '0;
                  step  <= 1'b1;
                  state <= ST_WAIT;
                  if (!reversal) begin
                     way <= pend;
                  end
               end else begin
                  acc <= sum[24:0];
               end
            end

            ST_WAIT: begin
               if (bus.i_Ack) begin
                  if (bus.i_Dead) begin
                     state <= ST_STOP;
                  end else begin
                     if (bus.i_Eat) begin
                        speed <= speed_inc;
                        bcnt  <= '0;
                        boost <= 1'b1;
                     end else if (boost) begin
                        if (bcnt_inc == BST_W) begin
                           speed <= DEF_W;
                           boost <= 1'b0;
                           bcnt  <= '0;
                        end else begin
                           bcnt <= bcnt_inc;
                        end
                     end
                     state <= bus.i_Pause ? ST_PAUSE : ST_RUN;
                  end
               end else if (wd_fire) begin
                  state <= ST_STOP;
               end
            end

            ST_PAUSE: begin
               if (!bus.i_Pause) begin
                  state <= ST_RUN;
               end
            end

            ST_STOP: begin
               state <= ST_STOP;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_Step  = step;
   assign bus.o_Way   = way;
   assign bus.o_Speed = speed;
   assign bus.o_Boost = boost;
   assign bus.o_State = state;

   step_one_cycle: assert property (@(posedge i_Clk) disable iff (!i_Rst) step |=> !step);
   speed_in_range: assert property (@(posedge i_Clk) disable iff (!i_Rst) speed <= MAX_W);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scenario bench for snake_step_ctrl with a step scoreboard (expected direction and RUN-cycle count per step).
`timescale 1ns/1ps
module tb_snake_step_ctrl;
   localparam int LST  = 10;
   localparam int DEF  = 2;
   localparam int MAXS = 15;
   localparam int BST  = 16;
   localparam int WDC  = 255;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #20 clk = ~clk;

   snake_step_ctrl_if bus ();

   snake_step_ctrl #(
      .LST_CLK    (LST),
      .DEF_SPD    (DEF),
      .MAX_SPD    (MAXS),
      .BOOST_STEPS(BST),
      .WDOG_CYC   (WDC)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [1:0] way;
      int         runs;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_speed = DEF;
   logic exp_boost = 1'b0;
   int   exp_bcnt  = 0;

   function automatic void model_ack(input logic eat);
      if (eat) begin
         exp_speed = (exp_speed >= MAXS) ? MAXS : exp_speed + 1;
         exp_bcnt  = 0;
         exp_boost = 1'b1;
      end else if (exp_boost) begin
         exp_bcnt++;
         if (exp_bcnt == BST) begin
            exp_speed = DEF;
            exp_boost = 1'b0;
            exp_bcnt  = 0;
         end
      end
   endfunction

   function automatic int run_len(input int spd);
      return (LST + spd - 1) / spd;
   endfunction

   // Advances to the negedge showing o_Step, counting RUN cycles on the way.
   task automatic wait_step(output logic got, output int runs);
      int i;
      i    = 0;
      runs = 0;
      while (bus.o_Step !== 1'b1 && i < 200) begin
         if (bus.o_State === S_RUN) runs++;
         @(negedge clk);
         i++;
      end
      got = (bus.o_Step === 1'b1);
   endtask

   // Ack lands in the cycle after the o_Step cycle.
   task automatic do_ack(input logic eat, input logic dead);
      @(negedge clk);
      bus.i_Ack  = 1'b1;
      bus.i_Eat  = eat;
      bus.i_Dead = dead;
      @(negedge clk);
      bus.i_Ack  = 1'b0;
      bus.i_Eat  = 1'b0;
      bus.i_Dead = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.i_Push = 4'hF; bus.i_Pause = 1'b0;
      bus.i_Ack = 1'b0; bus.i_Eat = 1'b0; bus.i_Dead = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.o_State !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", bus.o_State, S_IDLE); end
      n_checks++; if (bus.o_Step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b required 0", bus.o_Step); end
      n_checks++; if (bus.o_Way !== 2'd0) begin n_fail++; $display("FAIL rst_way: got %0d required 0", bus.o_Way); end
      n_checks++; if (bus.o_Speed !== 5'(DEF)) begin n_fail++; $display("FAIL rst_speed: got %0d required %0d", bus.o_Speed, DEF); end
      n_checks++; if (bus.o_Boost !== 1'b0) begin n_fail++; $display("FAIL rst_boost: got %b required 0", bus.o_Boost); end
      n_checks++; if (bus.o_Timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b required 0", bus.o_Timeout); end
      rst_n = 1'b1;
      exp_speed = DEF; exp_boost = 1'b0; exp_bcnt = 0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.o_State !== S_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d required %0d", bus.o_State, S_IDLE); end
   endtask

   task automatic test_first_step(input logic [3:0] press, input logic [1:0] dir);
      logic got; int runs; exp_t e;
      bus.i_Push = press;
      @(negedge clk);
      bus.i_Push = 4'hF;
      n_checks++; if (bus.o_State !== S_RUN) begin n_fail++; $display("FAIL start_run: got %0d required %0d", bus.o_State, S_RUN); end
      e.way = dir; e.runs = run_len(DEF); sb.push_back(e);
      wait_step(got, runs);
      e = sb.pop_front();
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL first_step_seen: got %b required 1", got); end
      n_checks++; if (runs !== e.runs) begin n_fail++; $display("FAIL first_step_runs: got %0d required %0d", runs, e.runs); end
      n_checks++; if (bus.o_Way !== e.way) begin n_fail++; $display("FAIL first_step_way: got %0d required %0d", bus.o_Way, e.way); end
      n_checks++; if (bus.o_State !== S_WAIT) begin n_fail++; $display("FAIL first_step_wait: got %0d required %0d", bus.o_State, S_WAIT); end
      @(negedge clk);
      n_checks++; if (bus.o_Step !== 1'b0) begin n_fail++; $display("FAIL step_pulse_width: got %b required 0", bus.o_Step); end
      n_checks++; if (bus.o_Way !== e.way) begin n_fail++; $display("FAIL way_held: got %0d required %0d", bus.o_Way, e.way); end
   endtask

   task automatic test_eat_boost();
      logic got; int runs; exp_t e; logic eat;
      do_ack(1'b1, 1'b0); model_ack(1'b1);
      n_checks++; if (bus.o_Speed !== 5'd3) begin n_fail++; $display("FAIL eat_speed: got %0d required 3", bus.o_Speed); end
      n_checks++; if (bus.o_Boost !== 1'b1) begin n_fail++; $display("FAIL eat_boost: got %b required 1", bus.o_Boost); end
      for (int k = 0; k < 46; k++) begin
         eat = (k >= 16 && k < 30);
         e.way = 2'd0; e.runs = run_len(exp_speed); sb.push_back(e);
         wait_step(got, runs);
         e = sb.pop_front();
         n_checks++; if (got !== 1'b1 || runs !== e.runs) begin n_fail++; $display("FAIL boost_step_%0d: got seen=%b runs=%0d required runs=%0d", k, got, runs, e.runs); end
         do_ack(eat, 1'b0); model_ack(eat);
         n_checks++; if (bus.o_Speed !== 5'(exp_speed) || bus.o_Boost !== exp_boost) begin
            n_fail++; $display("FAIL boost_ack_%0d: got speed=%0d boost=%b required speed=%0d boost=%b", k, bus.o_Speed, bus.o_Boost, exp_speed, exp_boost);
         end
         if (k == 15) begin
            n_checks++; if (bus.o_Speed !== 5'd2 || bus.o_Boost !== 1'b0) begin n_fail++; $display("FAIL boost_expire: got speed=%0d boost=%b required 2/0", bus.o_Speed, bus.o_Boost); end
         end
         if (k == 29) begin
            n_checks++; if (bus.o_Speed !== 5'd15) begin n_fail++; $display("FAIL speed_saturate: got %0d required 15", bus.o_Speed); end
         end
      end
   endtask

   task automatic test_reversal();
      logic got; int runs; exp_t e;
      logic [3:0] presses [4];
      logic [1:0] ways [4];
      presses = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      ways    = '{2'd0, 2'd2, 2'd2, 2'd0};
      for (int k = 0; k < 4; k++) begin
         bus.i_Push = presses[k];
         e.way = ways[k]; e.runs = run_len(exp_speed); sb.push_back(e);
         wait_step(got, runs);
         bus.i_Push = 4'hF;
         e = sb.pop_front();
         n_checks++; if (got !== 1'b1 || bus.o_Way !== e.way || runs !== e.runs) begin
            n_fail++; $display("FAIL reversal_%0d: got seen=%b way=%0d runs=%0d required way=%0d runs=%0d", k, got, bus.o_Way, runs, e.way, e.runs);
         end
         do_ack(1'b0, 1'b0); model_ack(1'b0);
      end
   endtask

   task automatic test_pause();
      logic got; int runs; exp_t e;
      repeat (3) @(negedge clk);
      bus.i_Pause = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         n_checks++; if (bus.o_State !== S_PAUSE || bus.o_Step !== 1'b0) begin
            n_fail++; $display("FAIL pause_hold_%0d: got state=%0d step=%b required state=%0d step=0", k, bus.o_State, bus.o_Step, S_PAUSE);
         end
         @(negedge clk);
      end
      bus.i_Pause = 1'b0;
      @(negedge clk);
      e.way = 2'd0; e.runs = 2; sb.push_back(e);
      wait_step(got, runs);
      e = sb.pop_front();
      n_checks++; if (got !== 1'b1 || runs !== e.runs) begin n_fail++; $display("FAIL pause_resume: got seen=%b runs=%0d required runs=%0d", got, runs, e.runs); end
      bus.i_Pause = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.o_State !== S_WAIT) begin n_fail++; $display("FAIL pause_in_wait: got %0d required %0d", bus.o_State, S_WAIT); end
      do_ack(1'b0, 1'b0); model_ack(1'b0);
      n_checks++; if (bus.o_State !== S_PAUSE) begin n_fail++; $display("FAIL pause_at_ack: got %0d required %0d", bus.o_State, S_PAUSE); end
      bus.i_Pause = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.o_State !== S_RUN) begin n_fail++; $display("FAIL pause_release: got %0d required %0d", bus.o_State, S_RUN); end
   endtask

   task automatic test_dead();
      logic got; int runs; exp_t e; int bad;
      bus.i_Ack = 1'b1; bus.i_Eat = 1'b1;
      @(negedge clk);
      bus.i_Ack = 1'b0; bus.i_Eat = 1'b0;
      n_checks++; if (bus.o_Speed !== 5'(exp_speed) || bus.o_State !== S_RUN) begin
         n_fail++; $display("FAIL ack_outside_wait: got speed=%0d state=%0d required speed=%0d state=%0d", bus.o_Speed, bus.o_State, exp_speed, S_RUN);
      end
      e.way = 2'd0; e.runs = 4; sb.push_back(e);
      wait_step(got, runs);
      e = sb.pop_front();
      n_checks++; if (got !== 1'b1 || runs !== e.runs) begin n_fail++; $display("FAIL dead_step: got seen=%b runs=%0d required runs=%0d", got, runs, e.runs); end
      do_ack(1'b1, 1'b1);
      n_checks++; if (bus.o_State !== S_STOP) begin n_fail++; $display("FAIL dead_stop: got %0d required %0d", bus.o_State, S_STOP); end
      n_checks++; if (bus.o_Speed !== 5'(exp_speed)) begin n_fail++; $display("FAIL dead_speed: got %0d required %0d", bus.o_Speed, exp_speed); end
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         bus.i_Push  = 4'($urandom_range(0, 15));
         bus.i_Pause = 1'($urandom_range(0, 1));
         bus.i_Ack   = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus.o_Step !== 1'b0 || bus.o_State !== S_STOP) bad++;
      end
      bus.i_Push = 4'hF; bus.i_Pause = 1'b0; bus.i_Ack = 1'b0;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_sticky: got %0d bad cycles required 0", bad); end
   endtask

   task automatic test_watchdog();
      int cyc;
      test_first_step(4'b1011, 2'd2);
`ifdef SNAKE_STEP_WDOG_EN
      cyc = 1;
      while (bus.o_State !== S_STOP && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++; if (cyc !== WDC) begin n_fail++; $display("FAIL wdog_cycles: got %0d required %0d", cyc, WDC); end
      n_checks++; if (bus.o_Timeout !== 1'b1) begin n_fail++; $display("FAIL wdog_timeout: got %b required 1", bus.o_Timeout); end
`else
      cyc = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.o_Timeout !== 1'b0) cyc++;
      end
      n_checks++; if (bus.o_State !== S_WAIT) begin n_fail++; $display("FAIL wait_forever: got %0d required %0d", bus.o_State, S_WAIT); end
      n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL timeout_tied: got %0d high cycles required 0", cyc); end
`endif
   endtask

   initial begin
      bus.i_Push = 4'hF; bus.i_Pause = 1'b0;
      bus.i_Ack = 1'b0; bus.i_Eat = 1'b0; bus.i_Dead = 1'b0;
      test_reset();
      test_first_step(4'b1110, 2'd0);
      test_eat_boost();
      test_reversal();
      test_pause();
      test_dead();
      test_reset();
      test_watchdog();
      test_reset();
      test_first_step(4'b1110, 2'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
